// File: rtl/switch_event_generator.sv
// Debounced switch level to PRESS/RELEASE/LONG/REPEAT events, queued on a valid/ready stream.
// Latency: edge or terminal tick to event_valid is 1 clock; when the queue is full and not popping, new events are dropped and overflow is set.

module sev_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy,
  output logic [W-1:0] o_pop_dat,
  output logic         o_drop
);
  // First-word-fall-through queue; a push into a full queue is accepted only when the head pops in the same cycle.
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign o_pop_vld = (r_count != '0);
  assign w_pop     = o_pop_vld && i_pop_rdy;
  assign w_push    = i_push_vld && (!w_full || w_pop);
  assign o_drop    = i_push_vld && !w_push;
  assign o_pop_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

module switch_event_generator #(
  parameter int LONG_PRESS_TICKS = 100,
  parameter int REPEAT_TICKS     = 20,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sampling_trigger,
  input  logic       switch_in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [1:0] event_code,
  output logic       pressed,
  output logic       overflow,
  input  logic       overflow_clear
);
  localparam int MAX_TICKS = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int LONG_TERM = LONG_PRESS_TICKS - 1;
  localparam int REP_TERM  = (REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1;
  localparam bit REP_EN    = (REPEAT_TICKS != 0);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_prev_in;
  logic          r_overflow;
  logic          w_rise;
  logic          w_fall;
  logic          w_long_term;
  logic          w_rep_term;
  logic          w_push;
  logic [1:0]    w_code;
  logic          w_drop;

  assign w_rise      = switch_in && !r_prev_in;
  assign w_fall      = !switch_in && r_prev_in;
  assign w_long_term = (r_cnt == CW'(LONG_TERM));
  assign w_rep_term  = (r_cnt == CW'(REP_TERM));
  assign pressed     = r_prev_in;
  assign overflow    = r_overflow;

  // A falling edge always wins over a tick arriving in the same cycle.
  always_comb begin
    w_push = 1'b0;
    w_code = EV_PRESS;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_push = 1'b1;
          w_code = EV_PRESS;
        end
      end
      S_PRESSED: begin
        if (w_fall) begin
          w_push = 1'b1;
          w_code = EV_RELEASE;
        end else if (sampling_trigger && w_long_term) begin
          w_push = 1'b1;
          w_code = EV_LONG;
        end
      end
      S_HELD: begin
        if (w_fall) begin
          w_push = 1'b1;
          w_code = EV_RELEASE;
        end else if (sampling_trigger && REP_EN && w_rep_term) begin
          w_push = 1'b1;
          w_code = EV_REPEAT;
        end
      end
      default: begin
        w_push = 1'b0;
        w_code = EV_PRESS;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prev_in  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_in <= switch_in;
      if (w_drop)              r_overflow <= 1'b1;
      else if (overflow_clear) r_overflow <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_state <= S_PRESSED;
          end
        end
        S_PRESSED: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end else if (sampling_trigger) begin
            if (w_long_term) begin
              r_cnt   <= '0;
              r_state <= S_HELD;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_HELD: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end else if (sampling_trigger && REP_EN) begin
            if (w_rep_term) r_cnt <= '0;
            else            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  sev_fifo #(
    .W     (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push_vld (w_push),
    .i_push_dat (w_code),
    .o_pop_vld  (event_valid),
    .i_pop_rdy  (event_ready),
    .o_pop_dat  (event_code),
    .o_drop     (w_drop)
  );
endmodule

// File: doc/switch_event_generator.md
# switch_event_generator

Converts a clean, already-debounced switch level into a stream of discrete key events: press, release, long-press and auto-repeat. It sits directly downstream of the debounce filter, shares the same `sampling_trigger` tick, and hands events to firmware-facing logic through a valid/ready stream with a small event queue.

## Interface
Parameters:
- `LONG_PRESS_TICKS`, default 100: number of trigger ticks the switch must stay pressed before a LONG event is emitted. Must be ≥1.
- `REPEAT_TICKS`, default 20: trigger-tick period of REPEAT events after LONG. A value of 0 disables repeat.
- `FIFO_DEPTH`, default 4: event queue depth. Must be a power of two, ≥2.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sampling_trigger`  in  1  one-cycle tick; timing counters advance only on this tick.
- `switch_in`  in  1  debounced level, synchronous to `clock`; 1 means pressed.
- `event_valid`  out  1  queue head is valid.
- `event_ready`  in  1  consumer accepts the head when it is high together with `event_valid`.
- `event_code`  out  2  head event: 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- `pressed`  out  1  registered copy of `switch_in`, delayed by one cycle.
- `overflow`  out  1  sticky flag; set when an event is dropped because the queue is full.
- `overflow_clear`  in  1  clears `overflow`.

## Operation
- `prev_in` register samples `switch_in` every clock; `pressed` = `prev_in`.
- Edges are detected every clock (not gated by the tick). A rising edge means `switch_in`=1 while `prev_in`=0. A falling edge is the opposite.
- States:
  - IDLE: rising edge → push PRESS, clear counter, go to PRESSED.
  - PRESSED: falling edge → push RELEASE, go to IDLE. Otherwise, on a tick: if counter == `LONG_PRESS_TICKS`-1, push LONG, clear counter, go to HELD; else increment counter.
  - HELD: falling edge → push RELEASE, go to IDLE. Otherwise, on a tick with `REPEAT_TICKS`≠0: if counter == `REPEAT_TICKS`-1, push REPEAT and clear counter; else increment counter. With `REPEAT_TICKS`=0, HELD only waits for release.
- Falling edge and tick in the same cycle: only RELEASE is pushed; the counter is ignored.
- Counter width is `$clog2(max(LONG_PRESS_TICKS, REPEAT_TICKS)+1)`. It never wraps, because it is cleared at its terminal value.
- Queue: FIFO of 2-bit codes with FIFO_DEPTH entries, first-word-fall-through. `event_code` is meaningful only while `event_valid` is high.
- Push while full with no pop in the same cycle: the new event is dropped, the queue is unchanged, and `overflow` is set.
- Push while full with a pop in the same cycle: the push is accepted and nothing is dropped.
- Push while empty: the event becomes the head on the next cycle.
- `overflow_clear` and a new drop in the same cycle: `overflow` stays 1 (set wins).
- `event_code` and `event_valid` are stable while `event_valid`=1 and `event_ready`=0.

## Timing
- Reset (asynchronous assert) values:
  - `event_valid`=0, `event_code`=0, `pressed`=0, `overflow`=0.
  - State IDLE, counter 0, `prev_in`=0, queue empty.
- Release of `reset_n` with `switch_in` already 1 produces a PRESS event one cycle later. This is intended.
- Edge to `event_valid` latency, with the queue empty: 1 clock. Example: rising edge seen at clock N, `event_valid`=1 with PRESS from N+1.
- Tick to LONG/REPEAT latency: 1 clock after the terminal tick.
- LONG appears on the `LONG_PRESS_TICKS`-th tick strictly after the press edge cycle. REPEATs follow every `REPEAT_TICKS` ticks.
- A head pop takes effect at the clock edge where `event_valid`&`event_ready`=1. The next entry is presented in the following cycle.
- Full throughput is one event per clock.
- Reset asserted mid-operation: queued events are discarded and the state returns to IDLE immediately. No RELEASE is emitted.

## Test plan
- Short press: `LONG_PRESS_TICKS`=4, tick every 10 clocks, `event_ready`=1. Hold for 2 ticks, then release → exactly PRESS then RELEASE, each with `event_valid` high for 1 cycle.
- Long press with repeat: `LONG_PRESS_TICKS`=4, `REPEAT_TICKS`=2. Hold for 9 ticks after the press → PRESS, LONG (after tick 4), REPEAT (after ticks 6 and 8), then RELEASE on release.
- Release coincident with the terminal tick (tick 4) → PRESS, RELEASE only; no LONG.
- Backpressure: `FIFO_DEPTH`=4, `event_ready`=0, generate 5 events → 4 queued, `overflow`=1.
  - Drain → codes come out in order.
  - Pulse `overflow_clear` → `overflow`=0.
- Full queue plus a push and a pop in the same cycle → no drop, `overflow` stays 0, and the pushed event is last in the queue.
- Reset: assert `reset_n`=0 while in HELD with 2 events queued → all outputs are 0 immediately. After release with `switch_in`=0, no events are produced.
